// File: rtl/fifo_rd_burst_if.sv
// fifo_rd_burst_if: FIFO read port and output stream bundle for fifo_rd_burst.
// master is the burst reader; slave is the FIFO plus downstream sink.
interface fifo_rd_burst_if #(parameter int DSIZE = 8);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  modport master (input rempty, rdata, m_ready, output rinc, m_data, m_valid, m_last);
  modport slave  (output rempty, rdata, m_ready, input rinc, m_data, m_valid, m_last);
endinterface

// File: rtl/fifo_rd_burst.sv
// fifo_rd_burst: pops fixed-length bursts from a FIFO into a 2-deep valid/ready buffer.
// Optional FIFO_RD_CNT_EN adds a 16-bit wrapping count of popped words on rd_count.
module fifo_rd_burst #(
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic rclk,
  input  logic rrst,
  fifo_rd_burst_if.master bus,
  input  logic enable,
  output logic busy
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0] rd_count
`endif
);
  localparam int BW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t           state, state_n;
  logic [BW-1:0]    beat;
  logic [1:0]       occ;
  logic [DSIZE-1:0] d0, d1;
  logic             l0, l1;
  logic             push, pop, last_beat;
  assign last_beat = beat == BW'(BURST - 1);
  always_ff @(posedge rclk or posedge rrst)
    if (rrst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && enable && !bus.rempty) state_n = READ;
    else if (state == READ && push && last_beat) state_n = DRAIN;
    else if (state == DRAIN && (occ == 2'd0 || (occ == 2'd1 && pop))) state_n = IDLE;
  end
  // Pop decision uses only registered state and rempty, keeping m_ready off this path.
  always_comb begin
    push        = state == READ && !bus.rempty && occ != 2'd2 && beat < BW'(BURST);
    bus.rinc    = push;
    bus.m_valid = occ != 2'd0;
    pop         = bus.m_valid && bus.m_ready;
    bus.m_data  = d0;
    bus.m_last  = bus.m_valid && l0;
    busy        = state != IDLE;
  end
  always_ff @(posedge rclk or posedge rrst)
    if (rrst) beat <= '0;
    else if (state != READ) beat <= '0;
    else if (push) beat <= beat + 1'b1;
  // Entry 0 is the head; entry 1 only fills when the head is occupied and not leaving.
  always_ff @(posedge rclk or posedge rrst)
    if (rrst) begin
      occ <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop && occ == 2'd2) {l0, d0} <= {l1, d1};
      else if (push && (occ == 2'd0 || pop)) {l0, d0} <= {last_beat, bus.rdata};
      if (push && occ == 2'd1 && !pop) {l1, d1} <= {last_beat, bus.rdata};
    end
`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge rclk or posedge rrst)
    if (rrst) rd_count <= 16'd0;
    else if (push) rd_count <= rd_count + 16'd1;
`endif
endmodule
